// File: rtl/mdu_pkg.sv
// Shared encodings, FSM state type and sizing for the iterative multiply/divide unit.
package mdu_pkg;

  localparam int unsigned DATA_W     = 32;
  localparam int unsigned ITER_COUNT = 32;
  localparam int unsigned CNT_W      = $clog2(ITER_COUNT);

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // Per-operation context latched at the accepting edge
  typedef struct packed {
    logic is_div;
    logic neg_lo;
    logic neg_hi;
    logic div_zero;
  } op_ctx_t;

  function automatic logic [DATA_W-1:0] magnitude(input logic [DATA_W-1:0] v,
                                                 input logic              is_signed);
    return (is_signed && v[DATA_W-1]) ? DATA_W'(-v) : v;
  endfunction

endpackage

// File: rtl/mdu_divstep.sv
// One restoring-division step: shift in the next dividend bit and subtract if it fits.
module mdu_divstep
  import mdu_pkg::*;
(
  input  logic [DATA_W-1:0] rem,
  input  logic              dividend_bit,
  input  logic [DATA_W-1:0] divisor,
  output logic [DATA_W-1:0] rem_next_c,
  output logic              q_bit_c
);

  logic [DATA_W:0] shifted;
  logic [DATA_W:0] diff;

  assign shifted = {rem, dividend_bit};
  assign diff    = shifted - {1'b0, divisor};

  // Borrow out of the 33-bit subtract means the divisor did not fit
  assign q_bit_c    = ~diff[DATA_W];
  assign rem_next_c = q_bit_c ? diff[DATA_W-1:0] : shifted[DATA_W-1:0];

endmodule

// File: rtl/mult_div_unit.sv
// Iterative HI/LO multiply/divide unit: fixed 32-cycle MULT/MULTU/DIV/DIVU plus MTHI/MTLO writes.
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] W_data,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  state_e           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  op_ctx_t          ctx;
  logic [WIDTH-1:0] opnd, acc_hi, acc_lo;

  logic accept_c, last_c, mt_en_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start) state_nxt = ST_RUN;
      ST_RUN:  if (cnt == CNT_W'(ITER_COUNT - 1)) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    accept_c = 1'b0;
    last_c   = 1'b0;
    mt_en_c  = 1'b0;
    case (state)
      ST_IDLE: begin
        accept_c = start;
        mt_en_c  = ~start;
      end
      ST_RUN:  last_c = (cnt == CNT_W'(ITER_COUNT - 1));
      default: ;
    endcase
  end

  assign busy = (state == ST_RUN);

  op_e  op_c;
  logic sgn_c, is_div_c;

  assign op_c     = op_e'(op);
  assign sgn_c    = (op_c == OP_MULT) || (op_c == OP_DIV);
  assign is_div_c = (op_c == OP_DIV)  || (op_c == OP_DIVU);

  // Shift-add: {acc_hi, acc_lo} holds partial product over remaining multiplier bits
  logic [WIDTH:0] msum_c;
  assign msum_c = {1'b0, acc_hi} + {1'b0, (acc_lo[0] ? opnd : {WIDTH{1'b0}})};

  logic [WIDTH-1:0] drem_c;
  logic             dq_c;

  mdu_divstep u_divstep (
    .rem          (acc_hi),
    .dividend_bit (acc_lo[WIDTH-1]),
    .divisor      (opnd),
    .rem_next_c   (drem_c),
    .q_bit_c      (dq_c)
  );

  logic [WIDTH-1:0] step_hi_c, step_lo_c;
  assign step_hi_c = ctx.is_div ? drem_c : msum_c[WIDTH:1];
  assign step_lo_c = ctx.is_div ? {acc_lo[WIDTH-2:0], dq_c} : {msum_c[0], acc_lo[WIDTH-1:1]};

  // Sign correction and divide-by-zero override applied to the final step
  logic [2*WIDTH-1:0] prod_c;
  logic [WIDTH-1:0]   res_hi_c, res_lo_c;

  always_comb begin
    prod_c   = {step_hi_c, step_lo_c};
    res_hi_c = step_hi_c;
    res_lo_c = step_lo_c;
    if (!ctx.is_div) begin
      if (ctx.neg_lo) prod_c = -prod_c;
      res_hi_c = prod_c[2*WIDTH-1:WIDTH];
      res_lo_c = prod_c[WIDTH-1:0];
    end else begin
      if (ctx.neg_hi) res_hi_c = -step_hi_c;
      if (ctx.div_zero)     res_lo_c = {WIDTH{1'b1}};
      else if (ctx.neg_lo)  res_lo_c = -step_lo_c;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      ctx    <= '0;
      opnd   <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      done   <= 1'b0;
      HI     <= '0;
      LO     <= '0;
    end else begin
      done <= last_c;
      if (accept_c) begin
        cnt          <= '0;
        ctx.is_div   <= is_div_c;
        ctx.neg_lo   <= sgn_c & (A[WIDTH-1] ^ B[WIDTH-1]);
        ctx.neg_hi   <= sgn_c & is_div_c & A[WIDTH-1];
        ctx.div_zero <= is_div_c & (B == '0);
        opnd         <= is_div_c ? magnitude(B, sgn_c) : magnitude(A, sgn_c);
        acc_lo       <= is_div_c ? magnitude(A, sgn_c) : magnitude(B, sgn_c);
        acc_hi       <= '0;
      end else if (state == ST_RUN) begin
        cnt    <= cnt + CNT_W'(1);
        acc_hi <= step_hi_c;
        acc_lo <= step_lo_c;
        if (last_c) begin
          HI <= res_hi_c;
          LO <= res_lo_c;
        end
      end else if (mt_en_c) begin
        if (hi_we) HI <= W_data;
        if (lo_we) LO <= W_data;
      end
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed and randomized checks of mult_div_unit against an arithmetic reference model.
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        rst_n, start, hi_we, lo_we;
  logic [1:0]  op;
  logic [31:0] A, B, W_data;
  logic        busy, done;
  logic [31:0] HI, LO;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mult_div_unit #(.WIDTH(32)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .op     (op),
    .A      (A),
    .B      (B),
    .hi_we  (hi_we),
    .lo_we  (lo_we),
    .W_data (W_data),
    .busy   (busy),
    .done   (done),
    .HI     (HI),
    .LO     (LO)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic on the architectural meaning of each op
  function automatic void ref_model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] hi, output logic [31:0] lo);
    longint sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    hi = '0;
    lo = '0;
    case (o)
      2'b00: begin p = 64'(sa * sb); hi = p[63:32]; lo = p[31:0]; end
      2'b01: begin p = {32'h0, a} * {32'h0, b}; hi = p[63:32]; lo = p[31:0]; end
      2'b10: begin
        if (b == 32'h0) begin lo = 32'hFFFFFFFF; hi = a; end
        else begin q = sa / sb; r = sa % sb; lo = 32'(q); hi = 32'(r); end
      end
      default: begin
        if (b == 32'h0) begin lo = 32'hFFFFFFFF; hi = a; end
        else begin lo = a / b; hi = a % b; end
      end
    endcase
  endfunction

  function automatic logic [31:0] rnd_val();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'($urandom_range(0, 15));
      2:       return 32'hFFFFFFFF - 32'($urandom_range(0, 15));
      3:       return 32'h80000000;
      default: return $urandom;
    endcase
  endfunction

  task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input bit mt_start, input bit poke);
    logic [31:0] eh, el, hi0, lo0;
    int lat;
    ref_model(o, a, b, eh, el);
    @(negedge clk);
    hi0 = HI;
    lo0 = LO;
    start = 1'b1; op = o; A = a; B = b;
    if (mt_start) begin hi_we = 1'b1; lo_we = 1'b1; W_data = 32'hCAFEF00D; end
    @(posedge clk); #1;
    check("busy_set", 32'(busy), 32'd1);
    lat = 0;
    while (done !== 1'b1 && lat < 40) begin
      @(negedge clk);
      start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
      if (lat == 0) begin A = $urandom; B = $urandom; op = 2'($urandom); end
      if (poke && lat == 5) begin
        start = 1'b1; hi_we = 1'b1; W_data = 32'hDEADBEEF; A = $urandom; B = $urandom;
      end
      @(posedge clk); #1;
      lat++;
      if (done !== 1'b1) begin
        check("hold_hi", HI, hi0);
        check("hold_lo", LO, lo0);
        check("busy_run", 32'(busy), 32'd1);
      end
    end
    check("latency", 32'(lat), 32'd32);
    check("busy_end", 32'(busy), 32'd0);
    check("res_hi", HI, eh);
    check("res_lo", LO, el);
    @(negedge clk);
    start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    @(posedge clk); #1;
    check("done_clr", 32'(done), 32'd0);
    check("no_restart", 32'(busy), 32'd0);
    check("res_keep_hi", HI, eh);
  endtask

  initial begin
    int seen;
    rst_n = 1'b0; start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    op = 2'b00; A = '0; B = '0; W_data = '0;
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_hi", HI, 32'h0);
    check("rst_lo", LO, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    do_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0);
    do_op(2'b00, 32'hFFFFFFFD, 32'h00000005, 1'b0, 1'b0);
    do_op(2'b11, 32'h00000007, 32'h00000002, 1'b0, 1'b0);
    do_op(2'b10, 32'hFFFFFFF9, 32'h00000002, 1'b0, 1'b0);
    do_op(2'b10, 32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b0);
    do_op(2'b11, 32'h00001234, 32'h00000000, 1'b0, 1'b0);
    do_op(2'b10, 32'hFFFFFF00, 32'h00000000, 1'b0, 1'b0);
    do_op(2'b10, 32'h00000007, 32'hFFFFFFFE, 1'b1, 1'b0);
    do_op(2'b00, 32'h12345678, 32'h9ABCDEF0, 1'b0, 1'b1);

    // MTHI/MTLO in idle
    @(negedge clk); hi_we = 1'b1; lo_we = 1'b1; W_data = 32'h12345678;
    @(posedge clk); #1;
    check("mt_both_hi", HI, 32'h12345678);
    check("mt_both_lo", LO, 32'h12345678);
    @(negedge clk); hi_we = 1'b0; lo_we = 1'b0;

    for (int i = 0; i < 40; i++) begin
      do_op(2'($urandom), rnd_val(), rnd_val(), 1'b0, ($urandom_range(0, 3) == 0));
    end

    // Reset mid-operation aborts with no done pulse
    do_op(2'b01, 32'h0000FFFF, 32'h00010001, 1'b0, 1'b0);
    @(negedge clk); start = 1'b1; op = 2'b00; A = $urandom | 32'h1; B = $urandom | 32'h1;
    @(negedge clk); start = 1'b0;
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_hi", HI, 32'h0);
    check("abort_lo", LO, 32'h0);
    @(negedge clk); rst_n = 1'b1;
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done === 1'b1) seen++;
    end
    check("abort_no_done", 32'(seen), 32'd0);

    @(negedge clk); lo_we = 1'b1; W_data = 32'h00000055;
    @(posedge clk); #1;
    check("mtlo_lo", LO, 32'h00000055);
    check("mtlo_hi", HI, 32'h00000000);
    @(negedge clk); lo_we = 1'b0;

    do_op(2'b10, 32'hFFFFFFF9, 32'h00000002, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width; only 32 is supported.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port start  input  1  request a new operation (sampled only when busy=0).
REQ-005 SHALL have port op  input  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-006 SHALL have port A  input  32  operand rs (register-file R_data_1).
REQ-007 SHALL have port B  input  32  operand rt (register-file R_data_2).
REQ-008 SHALL have port hi_we  input  1  MTHI write enable.
REQ-009 SHALL have port lo_we  input  1  MTLO write enable.
REQ-010 SHALL have port W_data  input  32  MTHI/MTLO write data.
REQ-011 SHALL have port busy  output  1  operation in progress.
REQ-012 SHALL have port done  output  1  one-cycle pulse on result ready.
REQ-013 SHALL have port HI  output  32  HI register (MFHI source).
REQ-014 SHALL have port LO  output  32  LO register (MFLO source).

Function
REQ-015 SHALL implement FSM IDLE -> RUN on start while idle; RUN -> IDLE after 32 iterations; no other states.
REQ-016 SHALL capture A, B and op at the accepting edge; later changes on A/B/op SHALL NOT affect the result.
REQ-017 SHALL assert busy from the accepting edge N through the edge N+32, inclusive of that edge's update; busy=0 after edge N+32.
REQ-018 SHALL write HI/LO and pulse done=1 at edge N+32; done SHALL clear at edge N+33; fixed 32-cycle latency for all ops, including divide by zero.
REQ-019 SHALL ignore start while busy=1; no queuing.
REQ-020 MULT/MULTU: iterative shift-add, one bit per cycle; 64-bit product, HI=bits 63:32, LO=bits 31:0; MULT signed two's complement, MULTU unsigned.
REQ-021 DIVU: restoring division, one quotient bit per cycle; LO=quotient, HI=remainder.
REQ-022 DIV: divide magnitudes, then sign-correct; quotient truncates toward zero; remainder sign equals dividend sign.
REQ-023 DIV 0x80000000 / 0xFFFFFFFF SHALL give LO=0x80000000, HI=0x00000000.
REQ-024 Divide by zero (B=0, DIV or DIVU) SHALL give LO=0xFFFFFFFF, HI=A unchanged.
REQ-025 hi_we/lo_we in IDLE with start=0 SHALL load W_data into HI/LO at the next edge; both may be set together.
REQ-026 hi_we/lo_we while busy=1, or in the same cycle as an accepted start, SHALL be ignored.
REQ-027 HI/LO SHALL hold their values during RUN and change only at the completion edge or on an MTHI/MTLO write.

Reset
REQ-028 rst_n=0 SHALL immediately force IDLE, busy=0, done=0, HI=0, LO=0, iteration counter=0, and clear internal operand/accumulator registers.
REQ-029 Reset during RUN SHALL abort the operation with no done pulse; the first start after rst_n=1 SHALL run normally.

Structure
REQ-030 Package mdu_pkg SHALL hold the op encodings (OP_MULT, OP_MULTU, OP_DIV, OP_DIVU), the FSM state type, and ITER_COUNT=32.
REQ-031 Sub-module mdu_divstep (combinational: one restoring subtract/compare step) SHALL be used; all other logic stays in mult_div_unit.

Verification
REQ-032 MULTU A=0xFFFFFFFF B=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001; done exactly 32 cycles after the start edge, single cycle.
REQ-033 MULT A=0xFFFFFFFD (-3) B=5 -> HI=0xFFFFFFFF, LO=0xFFFFFFF1; DIVU A=7 B=2 -> LO=3, HI=1.
REQ-034 DIV A=0xFFFFFFF9 (-7) B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
REQ-035 DIVU A=0x00001234 B=0 -> LO=0xFFFFFFFF, HI=0x00001234 after 32 cycles.
REQ-036 While busy: pulse start with new operands and hi_we=1 W_data=0xDEADBEEF -> both ignored; first result intact, no second done.
REQ-037 Assert rst_n=0 ten cycles into a MULT -> HI=LO=0, busy=0, no done; then MTLO 0x55 in idle -> LO=0x55 next edge.
